// File: rtl/pipe_phy_responder.sv
// PHY-side PIPE command responder: answers PowerDown, receiver-detect and Rate commands
// with PhyStatus/RxStatus. Optional RxElectricalIdle model under `PIPE_RESP_ELECIDLE_EN`.
module pipe_phy_responder #(
  parameter int                     LANESNUMBER     = 16,
  parameter int                     PD_LATENCY      = 4,
  parameter int                     DETECT_LATENCY  = 20,
  parameter int                     RATE_LATENCY    = 8,
  parameter int                     RESET_HOLD      = 6,
  parameter logic [LANESNUMBER-1:0] RX_PRESENT_MASK = {LANESNUMBER{1'b1}}
) (
  input  logic                       CLK,
  input  logic                       lpreset,
  input  logic [4*LANESNUMBER-1:0]   PowerDown,
  input  logic [3:0]                 Rate,
  input  logic [LANESNUMBER-1:0]     TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]     TxElecIdle,
  output logic [LANESNUMBER-1:0]     PhyStatus,
  output logic [3*LANESNUMBER-1:0]   RxStatus,
  output logic [LANESNUMBER-1:0]     RxElectricalIdle,
  output logic                       busy
);

  localparam logic [7:0] PD_LOAD   = 8'(PD_LATENCY - 1);
  localparam logic [7:0] DET_LOAD  = 8'(DETECT_LATENCY - 1);
  localparam logic [7:0] RATE_LOAD = 8'(RATE_LATENCY - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(RESET_HOLD - 1);
  localparam logic [3:0] PD_P0     = 4'd0;
  localparam logic [3:0] PD_P1     = 4'd2;

  typedef enum logic [1:0] {IDLE, PD_WAIT, DET_WAIT, DET_HOLD} lane_state_e;

  logic       hold_q;
  logic [7:0] hold_cnt_q;
  logic [3:0] rate_shadow_q;
  logic       rate_act_q;
  logic [7:0] rate_cnt_q;
  logic       hold_last;
  logic       rate_change;
  logic       rate_fire;
  logic [LANESNUMBER-1:0] lane_busy;

  assign hold_last   = hold_q && (hold_cnt_q == 8'd0);
  assign rate_change = (Rate != rate_shadow_q);
  // A rate change in the terminal cycle reloads the count instead of firing.
  assign rate_fire   = !hold_q && rate_act_q && !rate_change && (rate_cnt_q == 8'd0);

  always_ff @(posedge CLK or posedge lpreset) begin
    if (lpreset) begin
      hold_q        <= 1'b1;
      hold_cnt_q    <= HOLD_LOAD;
      rate_shadow_q <= 4'd0;
      rate_act_q    <= 1'b0;
      rate_cnt_q    <= 8'd0;
    end else begin
      rate_shadow_q <= Rate;
      if (hold_q) begin
        rate_act_q <= 1'b0;
        if (hold_last) hold_q <= 1'b0;
        else           hold_cnt_q <= hold_cnt_q - 8'd1;
      end else if (rate_change) begin
        rate_act_q <= 1'b1;
        rate_cnt_q <= RATE_LOAD;
      end else if (rate_act_q) begin
        if (rate_cnt_q == 8'd0) rate_act_q <= 1'b0;
        else                    rate_cnt_q <= rate_cnt_q - 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < LANESNUMBER; gi++) begin : g_lane
    lane_state_e state_q;
    logic [3:0]  pd_shadow_q;
    logic [7:0]  cnt_q;
    logic        phy_q;
    logic [2:0]  rxs_q;
    logic [3:0]  pd_lane;
    logic        det;
    logic        pd_change;

    assign pd_lane   = PowerDown[4*gi +: 4];
    assign det       = TxDetectRx_Loopback[gi];
    assign pd_change = (pd_lane != pd_shadow_q);

    always_ff @(posedge CLK or posedge lpreset) begin
      if (lpreset) begin
        state_q     <= IDLE;
        pd_shadow_q <= 4'd0;
        cnt_q       <= 8'd0;
        phy_q       <= 1'b1;
        rxs_q       <= 3'b000;
      end else begin
        phy_q <= rate_fire;
        rxs_q <= 3'b000;
        if (hold_q) begin
          state_q     <= IDLE;
          pd_shadow_q <= pd_lane;
          phy_q       <= !hold_last;
        end else begin
          case (state_q)
            IDLE: begin
              if (pd_change) begin
                pd_shadow_q <= pd_lane;
                cnt_q       <= PD_LOAD;
                state_q     <= PD_WAIT;
              end else if (det && pd_lane == PD_P1) begin
                cnt_q   <= DET_LOAD;
                state_q <= DET_WAIT;
              end
            end
            PD_WAIT: begin
              if (pd_change) begin
                pd_shadow_q <= pd_lane;
                cnt_q       <= PD_LOAD;
              end else if (cnt_q == 8'd0) begin
                phy_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                cnt_q <= cnt_q - 8'd1;
              end
            end
            DET_WAIT: begin
              // Abort leaves the shadow untouched so IDLE picks up any PowerDown change.
              if (!det || pd_lane != PD_P1) begin
                state_q <= IDLE;
              end else if (cnt_q == 8'd0) begin
                phy_q   <= 1'b1;
                rxs_q   <= RX_PRESENT_MASK[gi] ? 3'b011 : 3'b000;
                state_q <= DET_HOLD;
              end else begin
                cnt_q <= cnt_q - 8'd1;
              end
            end
            DET_HOLD: begin
              if (!det) state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end

    assign PhyStatus[gi]        = phy_q;
    assign RxStatus[3*gi +: 3]  = rxs_q;
    assign lane_busy[gi]        = (state_q != IDLE);

`ifdef PIPE_RESP_ELECIDLE_EN
    logic eidle_q;
    always_ff @(posedge CLK or posedge lpreset) begin
      if (lpreset) eidle_q <= 1'b1;
      else         eidle_q <= !(RX_PRESENT_MASK[gi] && pd_lane == PD_P0 && !TxElecIdle[gi]);
    end
    assign RxElectricalIdle[gi] = eidle_q;
`endif
  end

`ifndef PIPE_RESP_ELECIDLE_EN
  logic unused_tx_elec_idle;
  assign unused_tx_elec_idle = ^TxElecIdle;
  assign RxElectricalIdle    = '0;
`endif

  assign busy = hold_q | rate_act_q | (|lane_busy);

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Directed bench for pipe_phy_responder: vector table for reset/PowerDown/detect,
// plus hand sequences for detect abort, rate collision and async reset mid-detect.
module tb_pipe_phy_responder;

  localparam logic [15:0] MASK    = 16'h00FF;
  localparam logic [47:0] RXS_LO8 = {24'h0, {8{3'b011}}};
`ifdef PIPE_RESP_ELECIDLE_EN
  localparam logic [15:0] EIDLE_EXP = 16'hFFFF;
`else
  localparam logic [15:0] EIDLE_EXP = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pd;
  logic [3:0]  rate;
  logic [15:0] det;
  logic [15:0] txei;
  logic [15:0] phy;
  logic [47:0] rxs;
  logic [15:0] reidle;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_phy_responder #(
    .LANESNUMBER(16), .PD_LATENCY(4), .DETECT_LATENCY(20), .RATE_LATENCY(8),
    .RESET_HOLD(6), .RX_PRESENT_MASK(MASK)
  ) dut (
    .CLK(clk), .lpreset(rst), .PowerDown(pd), .Rate(rate),
    .TxDetectRx_Loopback(det), .TxElecIdle(txei),
    .PhyStatus(phy), .RxStatus(rxs), .RxElectricalIdle(reidle), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pd;
    logic [15:0] det;
    logic [3:0]  rate;
    int          ticks;
    logic [15:0] phy;
    logic [47:0] rxs;
    logic        busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string name, input logic [15:0] ephy,
                           input logic [47:0] erxs, input logic ebusy);
    check({name, ".phy"},   64'(phy),    64'(ephy));
    check({name, ".rxs"},   64'(rxs),    64'(erxs));
    check({name, ".busy"},  64'(busy),   64'(ebusy));
    check({name, ".eidle"}, 64'(reidle), 64'(EIDLE_EXP));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles during which no PhyStatus pulse and no RxStatus may appear
  task automatic quiet(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s.quiet%0d.phy", name, k), 64'(phy), 64'h0);
      check($sformatf("%s.quiet%0d.rxs", name, k), 64'(rxs), 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'd3, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b1};
    vecs[1]  = '{4'd3, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b1};
    vecs[2]  = '{4'd3, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b1};
    vecs[3]  = '{4'd3, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b1};
    vecs[4]  = '{4'd3, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b1};
    vecs[5]  = '{4'd3, 16'h0000, 4'd0, 1,  16'h0000, 48'h0,   1'b0};
    vecs[6]  = '{4'd2, 16'h0000, 4'd0, 1,  16'h0000, 48'h0,   1'b1};
    vecs[7]  = '{4'd2, 16'h0000, 4'd0, 3,  16'h0000, 48'h0,   1'b1};
    vecs[8]  = '{4'd2, 16'h0000, 4'd0, 1,  16'hFFFF, 48'h0,   1'b0};
    vecs[9]  = '{4'd2, 16'h0000, 4'd0, 1,  16'h0000, 48'h0,   1'b0};
    vecs[10] = '{4'd2, 16'hFFFF, 4'd0, 1,  16'h0000, 48'h0,   1'b1};
    vecs[11] = '{4'd2, 16'hFFFF, 4'd0, 19, 16'h0000, 48'h0,   1'b1};
    vecs[12] = '{4'd2, 16'hFFFF, 4'd0, 1,  16'hFFFF, RXS_LO8, 1'b1};
    vecs[13] = '{4'd2, 16'hFFFF, 4'd0, 1,  16'h0000, 48'h0,   1'b1};
    vecs[14] = '{4'd2, 16'hFFFF, 4'd0, 30, 16'h0000, 48'h0,   1'b1};
    vecs[15] = '{4'd2, 16'h0000, 4'd0, 1,  16'h0000, 48'h0,   1'b0};

    rst  = 1'b1;
    pd   = {16{4'd3}};
    rate = 4'd0;
    det  = 16'h0000;
    txei = 16'hFFFF;
    #1;
    check_all("reset_async", 16'hFFFF, 48'h0, 1'b1);
    tick();
    tick();
    check_all("reset_clocked", 16'hFFFF, 48'h0, 1'b1);
    rst = 1'b0;

    // Table: reset hold, PowerDown 3->2, detect with held request
    for (int i = 0; i < 16; i++) begin
      pd   = {16{vecs[i].pd}};
      det  = vecs[i].det;
      rate = vecs[i].rate;
      if (vecs[i].ticks > 1) quiet($sformatf("vec%0d", i), vecs[i].ticks - 1);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].phy, vecs[i].rxs, vecs[i].busy);
    end

    // Lane 3 detect dropped halfway: no completion, then a fresh request completes
    det = 16'h0008;
    tick();
    check_all("abort_start", 16'h0000, 48'h0, 1'b1);
    quiet("abort_run", 9);
    det = 16'h0000;
    quiet("abort_after", 25);
    check("abort_idle.busy", 64'(busy), 64'h0);
    det = 16'h0008;
    tick();
    quiet("redet_run", 19);
    tick();
    check_all("redet_done", 16'h0008, 48'h600, 1'b1);
    det = 16'h0000;
    tick();
    check_all("redet_release", 16'h0000, 48'h0, 1'b0);

    // Rate 0->1, lane 5 PowerDown change 4 cycles later: both finish together
    rate = 4'd1;
    tick();
    check_all("rate_start", 16'h0000, 48'h0, 1'b1);
    quiet("rate_pre", 3);
    pd[23:20] = 4'd0;
    quiet("rate_mid", 4);
    tick();
    check_all("collide", 16'hFFFF, 48'h0, 1'b0);
    tick();
    check_all("collide_after", 16'h0000, 48'h0, 1'b0);

    // Lane 5 back to P1 alone
    pd[23:20] = 4'd2;
    quiet("lane5_pd", 4);
    tick();
    check_all("lane5_pulse", 16'h0020, 48'h0, 1'b0);

    // Async reset in the middle of a detect: no stale completion afterwards
    det = 16'hFFFF;
    tick();
    quiet("det_pre_rst", 5);
    #2;
    rst = 1'b1;
    #1;
    check_all("midrst_async", 16'hFFFF, 48'h0, 1'b1);
    det = 16'h0000;
    tick();
    tick();
    check_all("midrst_clocked", 16'hFFFF, 48'h0, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all($sformatf("midrst_hold%0d", k), 16'hFFFF, 48'h0, 1'b1);
    end
    tick();
    check_all("midrst_hold_end", 16'h0000, 48'h0, 1'b0);
    quiet("midrst_no_stale", 30);
    check("midrst_final.busy", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_phy_responder.md
Name: pipe_phy_responder

Overview:
PHY-side PIPE command responder. It sits opposite the PCIe LTSSM/TX block on the PIPE interface and answers MAC commands the way a real PHY does. Covered commands: PowerDown transitions, receiver detection (TxDetectRx_Loopback in P1) and Rate changes. For each it generates PhyStatus completion pulses and RxStatus detect results per lane, so the LTSSM detect and polling flow can be closed in simulation and FPGA loopback.

Parameters:
LANESNUMBER, 16, number of PIPE lanes
PD_LATENCY, 4, cycles from PowerDown change to PhyStatus pulse (1..255)
DETECT_LATENCY, 20, cycles from detect request to completion (1..255)
RATE_LATENCY, 8, cycles from Rate change to PhyStatus pulse (1..255)
RESET_HOLD, 6, cycles PhyStatus stays high after lpreset deasserts (1..255)
RX_PRESENT_MASK, 16'hFFFF, per-lane receiver-present result (bit i = lane i)

Ports:
CLK  input  1  PIPE clock
lpreset  input  1  asynchronous active-high reset
PowerDown  input  4*LANESNUMBER  per-lane power state; lane i at [4i+3:4i]; P0=0, P0s=1, P1=2, P2=3
Rate  input  4  link rate select (shared by all lanes)
TxDetectRx_Loopback  input  LANESNUMBER  per-lane receiver-detect request
TxElecIdle  input  LANESNUMBER  per-lane transmitter electrical idle
PhyStatus  output  LANESNUMBER  per-lane completion pulse; held high during reset hold
RxStatus  output  3*LANESNUMBER  per-lane status; lane i at [3i+2:3i]
RxElectricalIdle  output  LANESNUMBER  per-lane receiver electrical idle (see Optional Feature)
busy  output  1  OR of all lane states not IDLE, plus global rate or reset-hold activity

Behaviour:
- Reset (lpreset=1, async): PhyStatus all ones, RxStatus=0, busy=1, RxElectricalIdle all ones. All lane FSMs go to IDLE. The PowerDown and Rate shadow registers load the current inputs on the first clock after deassert.
- Reset hold: after deassert, PhyStatus stays all ones for RESET_HOLD cycles, then drops to 0 on all lanes in the same cycle. Commands are ignored during the hold; shadows keep tracking.
- Per-lane FSM states: IDLE, PD_WAIT, DET_WAIT, DET_HOLD. Each lane has an 8-bit down-counter.
- IDLE -> PD_WAIT: lane PowerDown differs from its shadow. The shadow updates and the counter loads PD_LATENCY-1.
- IDLE -> DET_WAIT: TxDetectRx_Loopback=1 and PowerDown==P1 (4'd2) with no PowerDown change. The counter loads DETECT_LATENCY-1.
- Priority: if a PowerDown change and a detect request arrive in the same cycle, the PowerDown change wins. Detect is re-evaluated once the lane returns to IDLE.
- PD_WAIT: when the counter reaches 0, drive a 1-cycle PhyStatus pulse and return to IDLE. A further PowerDown change during PD_WAIT updates the shadow and reloads the counter, giving one pulse only.
- DET_WAIT: when the counter reaches 0, drive a 1-cycle PhyStatus pulse.
  - RxStatus = 3'b011 if RX_PRESENT_MASK[i]=1, else 3'b000, valid in the pulse cycle only.
  - Go to DET_HOLD.
- DET_WAIT abort: if TxDetectRx_Loopback drops or PowerDown leaves P1 before completion, there is no pulse and no RxStatus. The lane goes to IDLE, where a PowerDown change is then handled normally.
- DET_HOLD: wait for TxDetectRx_Loopback=0, then go to IDLE. A held request never triggers a second detect.
- Rate: a change versus the shadow starts a global counter (RATE_LATENCY-1). At 0 every lane gets a 1-cycle PhyStatus pulse. A new Rate change during the count reloads the counter.
- Collision: a lane pulse and a rate pulse in the same cycle merge into a single high cycle (OR). RxStatus carries the detect result if one applies.
- RxStatus is 3'b000 in every cycle that is not a detect-completion cycle.
- All outputs are registered: the first pulse appears exactly LATENCY cycles after the cycle in which the change is sampled.

Optional Feature:
PIPE_RESP_ELECIDLE_EN
- Defined: RxElectricalIdle[i] is registered as 0 only when RX_PRESENT_MASK[i]=1, PowerDown lane i == P0 and TxElecIdle[i]=0; otherwise 1. It updates one cycle after its inputs, and reset drives all ones.
- Undefined: RxElectricalIdle is tied to all zeros, and TxElecIdle is unused.

Test Plan:
- Reset release with RESET_HOLD=6 -> PhyStatus=16'hFFFF for 6 cycles after deassert, then 16'h0000; busy drops once the hold ends.
- All lanes PowerDown 3->2 -> PhyStatus=16'hFFFF pulse for exactly 1 cycle, 4 cycles later; RxStatus stays 0.
- PowerDown=2, TxDetectRx_Loopback=16'hFFFF held, RX_PRESENT_MASK=16'h00FF -> after 20 cycles PhyStatus=16'hFFFF for 1 cycle:
  - RxStatus lanes 0-7 = 3'b011, lanes 8-15 = 3'b000.
  - No second pulse while the request stays held.
- Lane 3 detect request dropped at cycle 10 of 20 -> no PhyStatus[3] pulse; a new request then completes after 20 cycles.
- Rate 0->1, then lane 5 PowerDown change timed so both finish in the same cycle -> PhyStatus[5] high for a single cycle only; other lanes pulse from the rate change.
- lpreset asserted mid-DET_WAIT -> PhyStatus all ones immediately (async), RxStatus=0, and after release no stale detect completion occurs.
